// File: rtl/mrd_in_pack_p4.sv
// Store-and-forward packer: serial complex samples -> 4-lane words, whole packets
// released as gap-free bursts to the 4-parallel memory top when it reports sink_ready.
//
// state     | meaning
// I_IDLE    | waiting for sop; stray non-sop samples are dropped
// I_COLLECT | packing samples of an open packet into 4-lane words
// O_IDLE    | waiting for a queued packet and sink_ready
// O_SEND    | streaming one committed word per cycle until the eop word
module mrd_in_pack_p4 #(
  parameter int W     = 18,
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int NDESC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [W-1:0]     in_real,
  input  logic [W-1:0]     in_imag,
  input  logic [5:0]       in_size,
  output logic             in_ready,
  input  logic             sink_ready,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [4*W-1:0]   out_real,
  output logic [4*W-1:0]   out_imag,
  output logic [5:0]       out_size,
  output logic             err_abort,
  output logic             err_ovf
);

  localparam int DAW = $clog2(NDESC);
  localparam int DCW = DAW + 1;
  localparam int MW  = 8*W + 1;

  typedef enum logic {I_IDLE, I_COLLECT} in_state_t;
  typedef enum logic {O_IDLE, O_SEND} out_state_t;

  in_state_t  i_st, i_nxt;
  out_state_t o_st, o_nxt;

  logic [MW-1:0]  mem [DEPTH];
  logic [AW:0]    wr_ptr, commit_ptr, rd_ptr;
  logic [AW:0]    base, fill, wr_ptr_nxt, commit_nxt;
  logic [W-1:0]   stg_re [4];
  logic [W-1:0]   stg_im [4];
  logic [1:0]     lane, lane_eff, lane_nxt;
  logic [5:0]     size_q, desc_din;
  logic [5:0]     desc_mem [NDESC];
  logic [DAW-1:0] desc_wp, desc_rp;
  logic [DCW-1:0] desc_cnt;

  logic           accept, start, active, abort, ovf, wr_need, wr_en, push, pop, send;
  logic           first_q;
  logic [4*W-1:0] wr_re, wr_im;
  logic [MW-1:0]  wr_word, rd_word;

  assign in_ready = (desc_cnt < DCW'(NDESC));
  assign accept   = in_valid & in_ready;
  assign start    = accept & in_sop;
  assign desc_din = start ? in_size : size_q;
  assign fill     = base - rd_ptr;
  assign wr_word  = {in_eop, wr_im, wr_re};
  assign rd_word  = mem[rd_ptr[AW-1:0]];

  always_comb begin
    i_nxt      = i_st;
    lane_eff   = '0;
    lane_nxt   = lane;
    active     = 1'b0;
    abort      = 1'b0;
    ovf        = 1'b0;
    base       = wr_ptr;
    wr_en      = 1'b0;
    wr_ptr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    push       = 1'b0;
    if (accept) begin
      if (in_sop) begin
        active = 1'b1;
        abort  = (i_st == I_COLLECT);
        base   = abort ? commit_ptr : wr_ptr;
      end else if (i_st == I_COLLECT) begin
        active   = 1'b1;
        lane_eff = lane;
      end
    end
    wr_need = active & ((lane_eff == 2'd3) | in_eop);
    if (active) begin
      // fill[AW] set means DEPTH words outstanding: no room for this word
      if (wr_need && fill[AW]) begin
        ovf        = 1'b1;
        wr_ptr_nxt = commit_ptr;
        i_nxt      = I_IDLE;
        lane_nxt   = '0;
      end else begin
        wr_en      = wr_need;
        wr_ptr_nxt = wr_need ? base + 1'b1 : base;
        if (in_eop) begin
          commit_nxt = wr_ptr_nxt;
          push       = 1'b1;
          i_nxt      = I_IDLE;
          lane_nxt   = '0;
        end else begin
          i_nxt    = I_COLLECT;
          lane_nxt = lane_eff + 2'd1;
        end
      end
    end
  end

  // lanes below the current one come from staging, lanes above are zero-filled on eop
  always_comb begin
    wr_re = '0;
    wr_im = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < int'(lane_eff)) begin
        wr_re[j*W +: W] = stg_re[j[1:0]];
        wr_im[j*W +: W] = stg_im[j[1:0]];
      end else if (j == int'(lane_eff)) begin
        wr_re[j*W +: W] = in_real;
        wr_im[j*W +: W] = in_imag;
      end
    end
  end

  always_comb begin
    o_nxt = o_st;
    pop   = 1'b0;
    send  = 1'b0;
    case (o_st)
      O_IDLE: begin
        if ((desc_cnt != '0) && sink_ready) begin
          pop   = 1'b1;
          o_nxt = O_SEND;
        end
      end
      O_SEND: begin
        send = 1'b1;
        if (rd_word[MW-1]) o_nxt = O_IDLE;
      end
      default: o_nxt = O_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[base[AW-1:0]] <= wr_word;
    if (active) begin
      stg_re[lane_eff] <= in_real;
      stg_im[lane_eff] <= in_imag;
    end
    if (push) desc_mem[desc_wp] <= desc_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_st       <= I_IDLE;
      o_st       <= O_IDLE;
      lane       <= '0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      size_q     <= '0;
      desc_wp    <= '0;
      desc_rp    <= '0;
      desc_cnt   <= '0;
      first_q    <= 1'b0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      out_size   <= '0;
      err_abort  <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      i_st       <= i_nxt;
      o_st       <= o_nxt;
      lane       <= lane_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_nxt;
      err_abort  <= abort;
      err_ovf    <= ovf;
      if (start) size_q <= in_size;
      if (push) desc_wp <= desc_wp + 1'b1;
      if (pop) begin
        desc_rp  <= desc_rp + 1'b1;
        out_size <= desc_mem[desc_rp];
        first_q  <= 1'b1;
      end else if (send) begin
        first_q <= 1'b0;
      end
      case ({push, pop})
        2'b10:   desc_cnt <= desc_cnt + 1'b1;
        2'b01:   desc_cnt <= desc_cnt - 1'b1;
        default: desc_cnt <= desc_cnt;
      endcase
      if (send) rd_ptr <= rd_ptr + 1'b1;
      out_valid <= send;
      out_sop   <= send & first_q;
      out_eop   <= send & rd_word[MW-1];
      out_real  <= send ? rd_word[4*W-1:0] : '0;
      out_imag  <= send ? rd_word[8*W-1:4*W] : '0;
    end
  end

endmodule
